// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: byte width and drain FSM states.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    StIdle       = 2'd0,
    StStrobe     = 2'd1,
    StWaitAccept = 2'd2,
    StWaitDone   = 2'd3
  } drain_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO with count, full/empty flags and a sticky overflow flag.
// Optional synchronous clear via flush_i when UART_TX_FIFO_FLUSH_EN is defined.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
`ifdef UART_TX_FIFO_FLUSH_EN
  input  logic                   flush_i,
`endif
  input  logic                   push_i,
  input  logic [UART_BYTE_W-1:0] push_data_i,
  input  logic                   pop_i,
  output logic [UART_BYTE_W-1:0] rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [ADDR_W:0]        level_o,
  output logic                   overflow_o
);

  localparam logic [ADDR_W:0] FullCnt = (ADDR_W + 1)'(DEPTH);

  logic [UART_BYTE_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]        count_q, count_d;
  logic                   overflow_q;
  logic                   flush, push_ok, pop_ok;

`ifdef UART_TX_FIFO_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign full_o     = (count_q == FullCnt);
  assign empty_o    = (count_q == '0);
  assign level_o    = count_q;
  assign overflow_o = overflow_q;
  assign rd_data_o  = mem_q[rd_ptr_q];

  // Fullness is judged on the current count, so a simultaneous pop never frees a slot.
  assign push_ok = push_i & ~full_o & ~flush;
  assign pop_ok  = pop_i & ~empty_o & ~flush;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      count_q <= count_d;
      if (push_i && full_o) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit buffer: byte FIFO drained through a write/busy handshake FSM.
// Define UART_TX_FIFO_FLUSH_EN to add the flush_i port.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
`ifdef UART_TX_FIFO_FLUSH_EN
  input  logic                   flush_i,
`endif
  input  logic                   push_i,
  input  logic [UART_BYTE_W-1:0] push_data_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [ADDR_W:0]        level_o,
  output logic                   overflow_o,
  output logic                   idle_o,
  output logic                   uart_write_o,
  output logic [UART_BYTE_W-1:0] uart_data_o,
  input  logic                   uart_busy_i
);

  drain_state_e           state_q, state_d;
  logic                   pop, flush;
  logic                   write_q;
  logic [UART_BYTE_W-1:0] data_q, rd_data;

`ifdef UART_TX_FIFO_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_i     (clock_i),
    .reset_ni    (reset_ni),
`ifdef UART_TX_FIFO_FLUSH_EN
    .flush_i     (flush_i),
`endif
    .push_i      (push_i),
    .push_data_i (push_data_i),
    .pop_i       (pop),
    .rd_data_o   (rd_data),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .level_o     (level_o),
    .overflow_o  (overflow_o)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A flush wins over a pop; the FIFO is being cleared this cycle.
        if (!empty_o && !uart_busy_i && !flush) begin
          pop     = 1'b1;
          state_d = StStrobe;
        end
      end
      StStrobe:     state_d = StWaitAccept;
      StWaitAccept: if (uart_busy_i) state_d = StWaitDone;
      StWaitDone:   if (!uart_busy_i) state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      write_q <= (state_d == StStrobe);
      if (pop) data_q <= rd_data;
    end
  end

  assign uart_write_o = write_q;
  assign uart_data_o  = data_q;
  assign idle_o       = empty_o & (state_q == StIdle);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model, transmitter busy model,
// directed scenarios and a randomized phase.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       flush = 1'b0;
  logic       busy = 1'b0;
  logic       full, empty, overflow, idle, uart_write;
  logic [4:0] level;
  logic [7:0] uart_data;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH (DEPTH)
  ) dut (
    .clock_i      (clk),
    .reset_ni     (rst_n),
`ifdef UART_TX_FIFO_FLUSH_EN
    .flush_i      (flush),
`endif
    .push_i       (push),
    .push_data_i  (push_data),
    .full_o       (full),
    .empty_o      (empty),
    .level_o      (level),
    .overflow_o   (overflow),
    .idle_o       (idle),
    .uart_write_o (uart_write),
    .uart_data_o  (uart_data),
    .uart_busy_i  (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_q[$];
  bit         m_ovf, m_inflight, m_need_rise, m_write, m_pop, m_full;
  logic [7:0] m_data;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_ovf = 0; m_inflight = 0; m_need_rise = 0; m_write = 0; m_data = 8'h00;
    end else begin
      m_full = (m_q.size() == DEPTH);
      m_pop  = !m_inflight && m_q.size() > 0 && !busy && !flush;
      // A byte stays in flight until the transmitter has raised busy after the strobe and dropped it.
      if (m_inflight && !m_write) begin
        if (m_need_rise && busy) m_need_rise = 0;
        else if (!m_need_rise && !busy) m_inflight = 0;
      end
      if (m_pop) begin
        m_data = m_q.pop_front();
        m_inflight = 1; m_need_rise = 1;
      end
      m_write = m_pop;
      if (flush) begin
        m_q.delete();
        m_ovf = 0;
      end else if (push) begin
        if (m_full) m_ovf = 1;
        else m_q.push_back(push_data);
      end
    end
  end

  // ---------------- transmitter busy model ----------------
  bit hold_busy = 0, rnd_busy = 0, wr_seen = 0;
  int bdelay = 1, blen = 20, dly = 0, hi = 0;

  initial forever begin
    @(posedge clk); #2;
    if (hold_busy) begin busy = 1; dly = 0; hi = 0; end
    else if (dly > 0) begin dly--; if (dly == 0) begin busy = 1; hi = blen; end end
    else if (hi > 0) begin hi--; if (hi == 0) busy = 0; end
    else busy = 0;
    if (wr_seen && !hold_busy) begin
      if (rnd_busy) begin bdelay = $urandom_range(1, 4); blen = $urandom_range(1, 8); end
      if (bdelay <= 1) begin busy = 1; hi = blen; end
      else dly = bdelay - 1;
    end
  end

  // ---------------- per-cycle compare and receive scoreboard ----------------
  logic [7:0] rx_q[$];
  int  strobes = 0, max_level = 0;
  bit  full_seen = 0, prev_write = 0;

  initial forever begin
    @(negedge clk);
    chk("level", level, m_q.size());
    chk("full", full, m_q.size() == DEPTH);
    chk("empty", empty, m_q.size() == 0);
    chk("overflow", overflow, m_ovf);
    chk("uart_write", uart_write, m_write);
    chk("uart_data", uart_data, m_data);
    chk("idle", idle, m_q.size() == 0 && !m_inflight);
    if (prev_write) chk("write_one_cycle", uart_write, 0);
    prev_write = uart_write;
    wr_seen = uart_write;
    if (uart_write) begin rx_q.push_back(uart_data); strobes++; end
    if (level > max_level) max_level = level;
    if (full) full_seen = 1;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_byte(input logic [7:0] b);
    push = 1; push_data = b;
    tick();
    push = 0;
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      tick();
      if (idle && !busy && hi == 0 && dly == 0 && !uart_write) break;
    end
    chk(nm, i < maxc, 1);
  endtask

  task automatic clear_sb();
    rx_q.delete(); strobes = 0; max_level = 0; full_seen = 0;
  endtask

  initial begin
    tick(3);
    // reset values
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_write", uart_write, 0);
    chk("rst_data", uart_data, 8'h00);
    chk("rst_idle", idle, 1);
    rst_n = 1;
    tick(2);

    // single byte latency
    bdelay = 1; blen = 20; clear_sb();
    push_byte(8'hA5);
    @(negedge clk); chk("t1_write_n1", uart_write, 0);
    @(negedge clk); chk("t1_write_n2", uart_write, 1);
    chk("t1_data", uart_data, 8'hA5);
    tick();
    wait_idle("t1_drain", 60);
    chk("t1_idle", idle, 1);
    chk("t1_data_held", uart_data, 8'hA5);
    chk("t1_strobes", strobes, 1);

    // 16-byte burst, slow transmitter
    clear_sb();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    wait_idle("t2_drain", 600);
    chk("t2_max_level", max_level, 15);
    chk("t2_full_seen", full_seen, 0);
    chk("t2_strobes", strobes, 16);
    chk("t2_rx_count", rx_q.size(), 16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++) chk("t2_rx_order", rx_q[i], i);

    // overflow while the transmitter is held busy
    clear_sb();
    hold_busy = 1; tick(2);
    for (int i = 0; i < 16; i++) push_byte(8'h30 + 8'(i));
    chk("t3_level16", level, 16);
    chk("t3_full", full, 1);
    chk("t3_ovf_before", overflow, 0);
    push_byte(8'hEE);
    chk("t3_level_after_drop", level, 16);
    chk("t3_ovf", overflow, 1);
    chk("t3_no_strobe_busy", strobes, 0);
    hold_busy = 0; bdelay = 1; blen = 3;
    wait_idle("t3_drain", 300);
    chk("t3_rx_count", rx_q.size(), 16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++) chk("t3_rx_order", rx_q[i], 8'h30 + i);
    chk("t3_ovf_sticky", overflow, 1);

    // transmitter slow to accept
    clear_sb();
    bdelay = 6; blen = 4;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    wait_idle("t4_drain", 200);
    chk("t4_strobes", strobes, 3);
    chk("t4_rx_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      chk("t4_rx0", rx_q[0], 8'h11);
      chk("t4_rx1", rx_q[1], 8'h22);
      chk("t4_rx2", rx_q[2], 8'h33);
    end

    // reset while waiting for busy to fall with bytes queued
    clear_sb();
    bdelay = 1; blen = 30;
    for (int i = 0; i < 4; i++) push_byte(8'h50 + 8'(i));
    tick(4);
    chk("t5_level_pre", level, 3);
    rst_n = 0; #1;
    chk("t5_async_level", level, 0);
    chk("t5_async_write", uart_write, 0);
    chk("t5_async_data", uart_data, 8'h00);
    chk("t5_async_ovf", overflow, 0);
    chk("t5_async_idle", idle, 1);
    tick(2);
    rst_n = 1;
    strobes = 0;
    tick(40);
    chk("t5_level_post", level, 0);
    chk("t5_no_strobe", strobes, 0);

`ifdef UART_TX_FIFO_FLUSH_EN
    // flush with bytes queued and one in flight
    clear_sb();
    bdelay = 1; blen = 15;
    for (int i = 0; i < 6; i++) push_byte(8'h70 + 8'(i));
    chk("t7_level_pre", level, 5);
    flush = 1; push = 1; push_data = 8'hFF;
    tick();
    flush = 0; push = 0;
    chk("t7_level", level, 0);
    chk("t7_ovf", overflow, 0);
    wait_idle("t7_drain", 100);
    chk("t7_strobes", strobes, 1);
`endif

    // randomized traffic
    rnd_busy = 1;
    for (int c = 0; c < 1500; c++) begin
      push = ($urandom_range(0, 99) < 45);
      push_data = 8'($urandom);
`ifdef UART_TX_FIFO_FLUSH_EN
      flush = ($urandom_range(0, 99) < 2);
`endif
      tick();
    end
    push = 0; flush = 0;
    wait_idle("rnd_drain", 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side buffer placed directly upstream of the UART transmitter.
- Accepts bytes from the CPU/peripheral bus at full clock rate and stores them in a circular FIFO.
- Drains them one at a time into the transmitter's write/busy handshake: one-cycle write strobe, stable data, wait for busy to rise then fall.
- Lets software queue a burst without polling busy per byte.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clock_i  input  1  system clock; all logic on rising edge.
- reset_ni  input  1  asynchronous active-low reset.
- push_i  input  1  write push_data_i into FIFO this cycle.
- push_data_i  input  8  byte to enqueue.
- full_o  output  1  FIFO holds DEPTH entries.
- empty_o  output  1  FIFO holds 0 entries (not counting the byte in flight).
- level_o  output  ADDR_W+1  current entry count, 0..DEPTH.
- overflow_o  output  1  sticky: a push was dropped because FIFO was full.
- idle_o  output  1  FIFO empty and drain FSM in IDLE (all bytes handed off and transmitter released busy).
- uart_write_o  output  1  write strobe to transmitter.
- uart_data_o  output  8  byte to transmitter.
- uart_busy_i  input  1  transmitter busy.

Behaviour:
- Reset (async assert, sync release): pointers=0, level_o=0, empty_o=1, full_o=0, overflow_o=0, uart_write_o=0, uart_data_o=8'h00, state=IDLE, idle_o=1.
- Storage: DEPTH x 8 register array; wr_ptr/rd_ptr ADDR_W bits, wrap naturally at DEPTH; count register ADDR_W+1 bits.
- Push: if push_i && !full_o, write mem[wr_ptr], wr_ptr++. If push_i && full_o, data dropped and overflow_o set (until reset).
- full_o is evaluated on the current count: a push while full is dropped even if a pop occurs the same cycle.
- Push and pop in the same non-full cycle: count unchanged, both pointers advance.
- Drain FSM states: IDLE, STROBE, WAIT_ACCEPT, WAIT_DONE.
  - IDLE: if count>0 && !uart_busy_i, pop (uart_data_o<=mem[rd_ptr], rd_ptr++, count--) and go to STROBE.
  - STROBE: uart_write_o=1 for exactly this one cycle; go to WAIT_ACCEPT.
  - WAIT_ACCEPT: uart_write_o=0; stay until uart_busy_i=1, then go to WAIT_DONE.
  - WAIT_DONE: stay until uart_busy_i=0, then go to IDLE.
- uart_write_o is registered (high iff state==STROBE); never high two consecutive cycles.
- uart_data_o is registered and held constant from the pop until the next pop.
- Latency: push in cycle N into an empty FIFO with FSM in IDLE and busy low -> pop in cycle N+1 -> uart_write_o high in cycle N+2.
- Back-to-back: the next pop happens in the first IDLE cycle after busy falls; minimum gap between strobes is 4 cycles.
- Busy already high in IDLE (transmitter in use by reset residue): no pop until it falls.
- Reset mid-operation: in-flight strobe aborted immediately; FIFO contents discarded.

Optional Feature:
- Macro: UART_TX_FIFO_FLUSH_EN.
- Defined: adds port flush_i (input, 1).
  - When high: pointers and count clear next edge, overflow_o clears, and any push that cycle is ignored.
  - The FSM is not disturbed: a byte already in STROBE/WAIT_* completes normally.
  - Flush has priority over push and pop in the same cycle.
- Undefined: no flush_i port; FIFO cleared only by reset_ni.

Decomposition:
- Shared package uart_pkg:
  - drain-state enum type: IDLE=2'd0, STROBE=2'd1, WAIT_ACCEPT=2'd2, WAIT_DONE=2'd3;
  - UART_BYTE_W=8 constant.
- One natural sub-module, uart_byte_fifo: storage, pointers, count, full/empty/overflow.
- uart_tx_fifo instantiates it and owns the drain FSM and output registers.

Test Plan:
- Reset then push 8'hA5 with busy held low, busy model rising 1 cycle after strobe and falling 20 cycles later -> uart_write_o high exactly cycle N+2, uart_data_o=8'hA5 until next pop, idle_o=1 after busy falls.
- Push 16 bytes 8'h00..8'h0F in consecutive cycles, DEPTH=16, slow busy model -> level_o reaches 15 (one popped), full_o never high, transmitter receives 00..0F in order, exactly 16 strobes each 1 cycle wide.
- Hold busy high, push 17 bytes -> full_o=1 at level 16, 17th byte dropped, overflow_o=1 and stays 1; after releasing busy, 16 bytes drain in order.
- Busy model with 5-cycle delay before asserting -> FSM holds WAIT_ACCEPT, uart_write_o stays 0, no second strobe, no byte lost.
- Assert reset_ni low during WAIT_DONE with 3 bytes queued -> outputs take reset values asynchronously; after release, level_o=0, no strobe.
- With UART_TX_FIFO_FLUSH_EN: flush_i pulsed while 5 queued, in WAIT_DONE, with simultaneous push -> level_o=0 next cycle, overflow_o=0, current byte completes, no further strobes.
